// File: rtl/score_text_writer.sv
// rtl/score_text_writer.sv - sequential binary-to-decimal HUD text writer (score, level, rows)
module score_text_writer #(
  parameter int ADDR_W     = 8,
  parameter int SCORE_BASE = 0,
  parameter int LEVEL_BASE = 16,
  parameter int ROWS_BASE  = 32
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     start,
  input  logic signed [31:0]       score,
  input  logic signed [31:0]       level,
  input  logic signed [31:0]       rows_cleared,
  output logic                     busy,
  output logic                     done,
  output logic                     char_we,
  output logic [ADDR_W-1:0]        char_addr,
  output logic [7:0]               char_code
);

  typedef enum logic [1:0] {IDLE, SUB, EMIT, DONE} state_t;

  state_t      state;
  logic [23:0] rem;
  logic [23:0] lvl_q;
  logic [23:0] rows_q;
  logic [3:0]  cnt;
  logic [3:0]  k;
  logic        lead;

  logic [23:0] score_c, level_c, rows_c;
  logic [23:0] pow;
  logic        last, blank;

  function automatic logic [23:0] sat(input logic signed [31:0] v, input int maxv);
    if (v < 0)
      return 24'd0;
    else if (v > maxv)
      return 24'(maxv);
    else
      return v[23:0];
  endfunction

  // k is the global character index 0..12 across score(7), level(2), rows(4)
  function automatic logic [23:0] pow_of(input logic [3:0] idx);
    case (idx)
      4'd0:    return 24'd1000000;
      4'd1:    return 24'd100000;
      4'd2:    return 24'd10000;
      4'd3:    return 24'd1000;
      4'd4:    return 24'd100;
      4'd5:    return 24'd10;
      4'd7:    return 24'd10;
      4'd9:    return 24'd1000;
      4'd10:   return 24'd100;
      4'd11:   return 24'd10;
      default: return 24'd1;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [3:0] idx);
    int a;
    if (idx < 4'd7)
      a = SCORE_BASE + int'(idx);
    else if (idx < 4'd9)
      a = LEVEL_BASE + int'(idx) - 7;
    else
      a = ROWS_BASE + int'(idx) - 9;
    return ADDR_W'(a);
  endfunction

  always_comb begin
    score_c = sat(score, 9999999);
    level_c = sat(level, 99);
    rows_c  = sat(rows_cleared, 9999);
    pow     = pow_of(k);
    last    = (k == 4'd6) || (k == 4'd8) || (k == 4'd12);
    blank   = lead && (cnt == 4'd0) && !last;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      rem       <= '0;
      lvl_q     <= '0;
      rows_q    <= '0;
      cnt       <= '0;
      k         <= '0;
      lead      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      char_we   <= 1'b0;
      char_addr <= '0;
      char_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem    <= score_c;
            lvl_q  <= level_c;
            rows_q <= rows_c;
            cnt    <= '0;
            k      <= '0;
            lead   <= 1'b1;
            busy   <= 1'b1;
            state  <= SUB;
          end
        end
        SUB: begin
          if (rem >= pow) begin
            rem <= rem - pow;
            cnt <= cnt + 4'd1;
          end else begin
            char_we   <= 1'b1;
            char_addr <= addr_of(k);
            char_code <= blank ? 8'h20 : (8'h30 + {4'd0, cnt});
            lead      <= blank;
            state     <= EMIT;
          end
        end
        EMIT: begin
          char_we <= 1'b0;
          cnt     <= '0;
          k       <= k + 4'd1;
          if (k == 4'd6) begin
            rem  <= lvl_q;
            lead <= 1'b1;
          end else if (k == 4'd8) begin
            rem  <= rows_q;
            lead <= 1'b1;
          end
          if (k == 4'd12) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= SUB;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_text_writer.sv
// tb/tb_score_text_writer.sv - randomized cycle-accurate check of score_text_writer
module tb_score_text_writer;

  logic               Clk = 1'b0;
  logic               Reset_n = 1'b1;
  logic               start = 1'b0;
  logic signed [31:0] score = 0;
  logic signed [31:0] level = 0;
  logic signed [31:0] rows_cleared = 0;
  logic               busy, done, char_we;
  logic [7:0]         char_addr;
  logic [7:0]         char_code;

  score_text_writer dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .score(score), .level(level), .rows_cleared(rows_cleared),
    .busy(busy), .done(done), .char_we(char_we),
    .char_addr(char_addr), .char_code(char_code)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int conv_start_edge = -1;
  int t_done = 0;
  bit mon_en = 1'b0;
  bit exp_we [0:255];
  int exp_addr [0:255];
  int exp_code [0:255];
  logic [7:0] cbuf [0:255];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, got, exp, $time);
    end
  endtask

  // Expected write schedule: digit d of the stream finishes after d+2 cycles.
  task automatic compute(input int s, input int l, input int r);
    int v [3];
    int w [3];
    int b [3];
    int mx [3];
    int t, p, d;
    bit lead, blank;
    v = '{s, l, r};
    w = '{7, 2, 4};
    b = '{0, 16, 32};
    mx = '{9999999, 99, 9999};
    for (int i = 0; i < 256; i++) exp_we[i] = 1'b0;
    t = 0;
    for (int f = 0; f < 3; f++) begin
      if (v[f] < 0) v[f] = 0;
      if (v[f] > mx[f]) v[f] = mx[f];
      lead = 1'b1;
      for (int i = 0; i < w[f]; i++) begin
        p = 1;
        for (int e = 0; e < w[f] - 1 - i; e++) p = p * 10;
        d = (v[f] / p) % 10;
        t = t + d + 2;
        blank = lead && (d == 0) && (i != w[f] - 1);
        if (!blank) lead = 1'b0;
        exp_we[t] = 1'b1;
        exp_addr[t] = b[f] + i;
        exp_code[t] = blank ? 32 : 48 + d;
      end
    end
    t_done = t + 1;
  endtask

  always @(posedge Clk) edge_cnt = edge_cnt + 1;

  int  mcyc;
  bit  m_busy, m_done, m_we;
  always @(negedge Clk) begin
    if (mon_en) begin
      mcyc = (conv_start_edge >= 0) ? edge_cnt - conv_start_edge + 1 : -1;
      m_busy = (mcyc >= 1) && (mcyc <= t_done);
      m_done = (mcyc >= 1) && (mcyc == t_done);
      m_we = (mcyc >= 0 && mcyc < 256) ? exp_we[mcyc] : 1'b0;
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("char_we", char_we, m_we);
      if (m_we) begin
        chk("char_addr", char_addr, exp_addr[mcyc]);
        chk("char_code", char_code, exp_code[mcyc]);
      end
      if (char_we) cbuf[char_addr] = char_code;
    end
  end

  function automatic int cur_cyc();
    return edge_cnt - conv_start_edge + 1;
  endfunction

  task automatic launch(input int s, input int l, input int r);
    score = s;
    level = l;
    rows_cleared = r;
    start = 1'b1;
    @(posedge Clk);
    #1;
    compute(s, l, r);
    for (int i = 0; i < 256; i++) cbuf[i] = 8'hff;
    conv_start_edge = edge_cnt;
    start = 1'b0;
  endtask

  // Inputs are scrambled while waiting to catch any re-sampling while busy.
  task automatic wait_until(input int c);
    while (cur_cyc() < c) begin
      @(negedge Clk);
      score = $urandom;
      level = $urandom;
      rows_cleared = $urandom;
    end
  endtask

  task automatic check_field(input int base, input string s);
    for (int i = 0; i < s.len(); i++)
      chk("buffer", cbuf[base + i], s[i]);
  endtask

  function automatic int rand_val();
    int tmp;
    case ($urandom_range(0, 4))
      0: return 0;
      1: begin tmp = $urandom_range(1, 1000); return -tmp; end
      2: return $urandom_range(0, 99);
      3: return $urandom_range(0, 20000000);
      default: return $urandom;
    endcase
  endfunction

  task automatic finish_conv();
    wait_until(t_done + 1);
  endtask

  initial begin
    #1 Reset_n = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", char_we, 0);
    chk("rst_addr", char_addr, 0);
    chk("rst_code", char_code, 0);
    #2 Reset_n = 1'b1;
    @(negedge Clk);

    launch(0, 0, 0);
    chk("t_done_zero", t_done, 27);
    finish_conv();
    check_field(0, "      0");
    check_field(16, " 0");
    check_field(32, "   0");

    launch(1234567, 5, 42);
    chk("t_done_mixed", t_done, 66);
    finish_conv();
    check_field(0, "1234567");
    check_field(16, " 5");
    check_field(32, "  42");

    launch(10000000, 150, -3);
    finish_conv();
    check_field(0, "9999999");
    check_field(16, "99");
    check_field(32, "   0");

    launch(9999999, 99, 9999);
    chk("t_done_max", t_done, 144);
    finish_conv();

    // start mid-conversion and in the DONE cycle are both dropped
    launch(305, 7, 1000);
    wait_until(5);
    score = 8888888; level = 88; rows_cleared = 8888; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    wait_until(t_done);
    score = 1; level = 1; rows_cleared = 1; start = 1'b1;
    wait_until(t_done + 1);
    launch(7654321, 12, 900);
    finish_conv();
    check_field(0, "7654321");
    check_field(16, "12");
    check_field(32, " 900");

    // reset mid-conversion
    launch(9999999, 99, 9999);
    wait_until(10);
    #2 Reset_n = 1'b0;
    conv_start_edge = -1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_we", char_we, 0);
    chk("abort_done", done, 0);
    chk("abort_addr", char_addr, 0);
    chk("abort_code", char_code, 0);
    repeat (3) @(negedge Clk);
    #2 Reset_n = 1'b1;
    @(negedge Clk);
    launch(406, 3, 51);
    finish_conv();
    check_field(0, "    406");
    check_field(16, " 3");
    check_field(32, "  51");

    for (int n = 0; n < 20; n++) begin
      launch(rand_val(), rand_val(), rand_val());
      finish_conv();
      if ($urandom_range(0, 1) == 1) @(negedge Clk);
    end

    repeat (2) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_text_writer.md
# score_text_writer

Sequential binary-to-decimal text writer for the HUD overlay. On a start pulse it snapshots `score`, `level` and `rows_cleared`, converts each to fixed-width decimal by power-of-ten subtraction, and writes one ASCII character code per digit into the character buffer. The text pixel path reads that buffer and the font ROM to draw glyphs. This block is the writer end of that buffer; the pixel path is the reader.

## Interface
Parameters:
- `ADDR_W`, 8: character-buffer address width.
- `SCORE_BASE`, 0: buffer address of the most significant score digit.
- `LEVEL_BASE`, 16: buffer address of the most significant level digit.
- `ROWS_BASE`, 32: buffer address of the most significant rows digit.

Ports:
- `Clk`  in  1: the single clock.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to refresh all three fields.
- `score`  in  32: signed `int`.
- `level`  in  32: signed `int`.
- `rows_cleared`  in  32: signed `int`.
- `busy`  out  1: high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1: one-cycle pulse when all 13 characters have been written.
- `char_we`  out  1: buffer write strobe.
- `char_addr`  out  ADDR_W: buffer write address.
- `char_code`  out  8: ASCII code to write, either 0x30–0x39 or 0x20 for a blank.

## Operation
Fields are processed in fixed order. Within a field, digits go most significant first, and each digit's address is the field base plus its digit index (0 = most significant).
- score: 7 digits, range 0..9_999_999.
- level: 2 digits, range 0..99.
- rows: 4 digits, range 0..9_999.

Value conditioning, applied at snapshot time:
- A negative input becomes 0.
- An input above the field maximum saturates to the maximum (all 9s).
- The remainder register is 24 bits wide, which is enough for 9_999_999.

States:
- **IDLE**
  - `start` = 1: snapshot all three inputs, load the remainder with the conditioned score, set power = 10^6, clear digit count, go to SUB.
  - `start` = 0: stay in IDLE.
- **SUB**
  - remainder >= power: remainder -= power, count += 1, stay in SUB.
  - otherwise: go to EMIT.
- **EMIT**
  - Drive `char_we` = 1, `char_addr` = base + index, and `char_code`.
    - `char_code` = 0x20 if count = 0, all earlier digits of this field were blank, and this is not the field's last digit.
    - Otherwise `char_code` = 0x30 + count.
  - Clear the count and step power down by one decade.
  - After a field's last digit, load the next field's conditioned value and its top power (10^1 for level, 10^3 for rows) and reset the blank-tracking flag.
  - After the 13th character, go to DONE. Otherwise return to SUB.
- **DONE**
  - Assert `done` = 1 for one cycle, then go to IDLE.

Rules:
- `start` is ignored in every state except IDLE. Inputs are not re-sampled while busy.
- The powers of ten come from a constant table. No divider is allowed.
- Reset values: state IDLE, all outputs 0, all internal registers 0.
- A `Reset_n` assertion mid-conversion aborts immediately. No further writes occur, and `done` does not pulse. Characters already written stay in the buffer.

## Timing
- `start` is sampled on the rising edge at cycle 0. The first SUB cycle is cycle 1.
- Digit d costs d+1 SUB cycles plus 1 EMIT cycle.
- Total cycles from the start edge to the DONE cycle = 27 + Σd over all 13 digits.
  - Minimum: 27, all inputs 0.
  - Maximum: 144, all fields saturated.
- `done` is high in cycle 27 + Σd.
- `busy` is high in cycles 1 through 27 + Σd.
- A new `start` is accepted at the earliest in the cycle after DONE.
- `char_*` outputs are registered. `char_we` is high only in EMIT cycles, giving exactly 13 write strobes per conversion. `char_addr` and `char_code` are stable for the whole EMIT cycle.
- A `start` arriving in the same cycle as DONE is dropped.

## Test plan
- All inputs 0, start:
  - 13 writes: score = six 0x20 then 0x30, level = 0x20 0x30, rows = three 0x20 then 0x30.
  - `done` at cycle 27.
- score = 1_234_567, level = 5, rows = 42:
  - Addresses 0–6 receive "1234567", 16–17 receive " 5", 32–35 receive "  42".
  - `done` at cycle 27+28+5+6 = 66.
- score = 10_000_000, level = 150, rows = -3:
  - Score saturates to "9999999", level to "99", and rows writes "   0".
- Repeated starts:
  - A second `start` at cycle 5 with different inputs causes no effect and no extra writes.
  - A `start` issued in the cycle after `done` runs a full conversion with the new values.
- `Reset_n` low at cycle 10 of a conversion:
  - Outputs read 0 immediately and state is IDLE.
  - No further `char_we` and no `done`.
  - After release, a `start` performs a full conversion.
- All fields at maximum (score = 9_999_999, level = 99, rows = 9_999):
  - Exactly 144 cycles from start to `done`.
  - `busy` stays continuously high through cycle 144.
